// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for 640x480@60 Hz VGA, running on the 25 MHz
//   pixel clock. Two free-running counters (h_cnt, v_cnt) are the only state.
//   Every output is a combinational decode of those counters.
//
// Ports
//   vga_clk     in   1   pixel clock
//   vga_rst     in   1   synchronous active-high reset
//   pixel_data  in  16   RGB565 from renderer, one cycle after its request
//   pixel_xpos  out 10   requested column (0 when data_req=0)
//   pixel_ypos  out 10   requested row    (0 when data_req=0)
//   data_req    out  1   coordinate request valid (one cycle ahead of beam)
//   vga_hs      out  1   horizontal sync
//   vga_vs      out  1   vertical sync
//   vga_rgb     out 16   RGB565 to DAC, black outside the active window
//   video_en    out  1   beam inside the active window
//   frame_tick  out  1   one-cycle pulse at start of vertical front porch
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int V_TOTAL  = 525,
  parameter int SYNC_POL = 0
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [15:0] vga_rgb,
  output logic        video_en,
  output logic        frame_tick
);

  // The sum of the interval widths is authoritative; a totals parameter that
  // disagrees with it is ignored so the raster can never run a short line.
  localparam int H_SUM    = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_SUM    = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_PERIOD = (H_TOTAL == H_SUM) ? H_TOTAL : H_SUM;
  localparam int V_PERIOD = (V_TOTAL == V_SUM) ? V_TOTAL : V_SUM;

  localparam logic [9:0] H_MAX      = 10'(H_PERIOD - 1);
  localparam logic [9:0] V_MAX      = 10'(V_PERIOD - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);

  // Active window start/end on each axis.
  localparam logic [9:0] HA         = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_LAST = 10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] VA         = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_LAST = 10'(V_SYNC + V_BACK + V_DISP - 1);
  localparam logic [9:0] V_TICK     = 10'(V_SYNC + V_BACK + V_DISP);

  // Request window is the active window shifted one column earlier, so the
  // renderer's registered response lines up with the beam.
  localparam logic [9:0] REQ_FIRST  = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] REQ_LAST   = 10'(H_SYNC + H_BACK + H_DISP - 2);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_req_win;
  logic       h_vid_win;
  logic       v_act_win;

  // Next-state: v_cnt only advances on the last column of a line.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_MAX) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_req_win  = (h_cnt_q >= REQ_FIRST) && (h_cnt_q <= REQ_LAST);
    h_vid_win  = (h_cnt_q >= HA) && (h_cnt_q <= H_ACT_LAST);
    v_act_win  = (v_cnt_q >= VA) && (v_cnt_q <= V_ACT_LAST);

    vga_hs     = (h_cnt_q < H_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
    vga_vs     = (v_cnt_q < V_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;

    data_req   = h_req_win && v_act_win;
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (data_req) begin
      pixel_xpos = h_cnt_q - REQ_FIRST;
      pixel_ypos = v_cnt_q - VA;
    end

    video_en   = h_vid_win && v_act_win;
    vga_rgb    = video_en ? pixel_data : 16'h0000;

    // Gated by reset so a reset landing on the tick cycle cannot leak a pulse.
    frame_tick = !vga_rst && (h_cnt_q == 10'd0) && (v_cnt_q == V_TICK);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Small raster for the multi-frame scenarios (full frames are 420000 cycles)
  localparam int B_HS = 4, B_HB = 3, B_HD = 8, B_HF = 2, B_HT = 17;
  localparam int B_VS = 2, B_VB = 3, B_VD = 6, B_VF = 2, B_VT = 13;
  localparam int B_FRAME = B_HT * B_VT;                 // 221
  localparam int B_TICK  = (B_VS + B_VB + B_VD) * B_HT; // 187

  logic vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // Default-parameter DUT
  logic        rst_a = 1'b1;
  logic [15:0] pix_a = 16'h0000;
  logic [9:0]  xpos_a, ypos_a;
  logic        req_a, hs_a, vs_a, ven_a, tick_a;
  logic [15:0] rgb_a;

  // Small-raster DUT, active-high sync
  logic        rst_b = 1'b1;
  logic [15:0] pix_b = 16'hF800;
  logic [9:0]  xpos_b, ypos_b;
  logic        req_b, hs_b, vs_b, ven_b, tick_b;
  logic [15:0] rgb_b;

  vga_timing_gen dut_a (
    .vga_clk(vga_clk), .vga_rst(rst_a), .pixel_data(pix_a),
    .pixel_xpos(xpos_a), .pixel_ypos(ypos_a), .data_req(req_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_rgb(rgb_a),
    .video_en(ven_a), .frame_tick(tick_a)
  );

  vga_timing_gen #(
    .H_SYNC(B_HS), .H_BACK(B_HB), .H_DISP(B_HD), .H_FRONT(B_HF), .H_TOTAL(B_HT),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_DISP(B_VD), .V_FRONT(B_VF), .V_TOTAL(B_VT),
    .SYNC_POL(1)
  ) dut_b (
    .vga_clk(vga_clk), .vga_rst(rst_b), .pixel_data(pix_b),
    .pixel_xpos(xpos_b), .pixel_ypos(ypos_b), .data_req(req_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_rgb(rgb_b),
    .video_en(ven_b), .frame_tick(tick_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_a = 0;
  int cyc_b = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {y[5:0], x} ^ 16'h1234;
  endfunction

  // Renderer model: registers the colour for the requested coordinate; outside
  // requests it drives a bright colour that the DUT must blank.
  always_ff @(posedge vga_clk) begin
    pix_a <= req_a ? pat(xpos_a, ypos_a) : 16'hF800;
  end

  task automatic test_reset();
    repeat (3) @(negedge vga_clk);
    n_cmp++; if (hs_a !== 1'b0) begin n_err++; $display("FAIL reset_hs got=%b exp=0", hs_a); end
    n_cmp++; if (vs_a !== 1'b0) begin n_err++; $display("FAIL reset_vs got=%b exp=0", vs_a); end
    n_cmp++; if (req_a !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", req_a); end
    n_cmp++; if (ven_a !== 1'b0) begin n_err++; $display("FAIL reset_ven got=%b exp=0", ven_a); end
    n_cmp++; if (rgb_a !== 16'h0) begin n_err++; $display("FAIL reset_rgb got=%h exp=0000", rgb_a); end
    n_cmp++; if (xpos_a !== 10'd0 || ypos_a !== 10'd0) begin
      n_err++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", xpos_a, ypos_a);
    end
    n_cmp++; if (tick_a !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", tick_a); end
    rst_a = 1'b0;
    cyc_a = 0;
    $display("test_reset: outputs sampled under reset, cycle 0 starts");
  endtask

  // Sync strobes from cycle 0 (counters at 0,0) up to 'last'.
  task automatic test_sync_timing(input int last, input string tag);
    logic e_hs, e_vs;
    while (cyc_a <= last) begin
      e_hs = ((cyc_a % 800) < 96) ? 1'b0 : 1'b1;
      e_vs = (cyc_a < 1600) ? 1'b0 : 1'b1;
      n_cmp++; if (hs_a !== e_hs) begin
        n_err++; $display("FAIL %s_hs cyc=%0d got=%b exp=%b", tag, cyc_a, hs_a, e_hs);
      end
      n_cmp++; if (vs_a !== e_vs) begin
        n_err++; $display("FAIL %s_vs cyc=%0d got=%b exp=%b", tag, cyc_a, vs_a, e_vs);
      end
      n_cmp++; if (req_a !== 1'b0 || ven_a !== 1'b0 || rgb_a !== 16'h0) begin
        n_err++; $display("FAIL %s_blank cyc=%0d got=req%b ven%b rgb%h exp=0/0/0000", tag, cyc_a, req_a, ven_a, rgb_a);
      end
      @(negedge vga_clk); cyc_a++;
    end
    $display("%s: sync strobes checked through cycle %0d", tag, last);
  endtask

  // Request lead, active window and RGB gating with a pixel scoreboard.
  task automatic test_active_window(input int last);
    int h, v, first_req, ven_line35;
    logic e_req, e_ven;
    logic [9:0] e_x, e_y;
    logic [15:0] e_rgb;
    first_req = -1;
    ven_line35 = 0;
    exp_q.delete();
    while (cyc_a <= last) begin
      h = cyc_a % 800;
      v = cyc_a / 800;
      e_req = (h >= 143 && h <= 782 && v >= 35 && v <= 514);
      e_ven = (h >= 144 && h <= 783 && v >= 35 && v <= 514);
      e_x = e_req ? 10'(h - 143) : 10'd0;
      e_y = e_req ? 10'(v - 35) : 10'd0;
      n_cmp++; if (req_a !== e_req) begin n_err++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc_a, req_a, e_req); end
      n_cmp++; if (ven_a !== e_ven) begin n_err++; $display("FAIL ven cyc=%0d got=%b exp=%b", cyc_a, ven_a, e_ven); end
      n_cmp++; if (xpos_a !== e_x || ypos_a !== e_y) begin
        n_err++; $display("FAIL pos cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc_a, xpos_a, ypos_a, e_x, e_y);
      end
      n_cmp++; if (tick_a !== 1'b0) begin n_err++; $display("FAIL tick_a cyc=%0d got=%b exp=0", cyc_a, tick_a); end
      if (ven_a) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rgb_sb cyc=%0d got=%h exp=<none queued>", cyc_a, rgb_a);
        end else begin
          e_rgb = exp_q.pop_front();
          n_cmp++; if (rgb_a !== e_rgb) begin n_err++; $display("FAIL rgb_sb cyc=%0d got=%h exp=%h", cyc_a, rgb_a, e_rgb); end
        end
      end else begin
        n_cmp++; if (rgb_a !== 16'h0) begin n_err++; $display("FAIL rgb_blank cyc=%0d got=%h exp=0000", cyc_a, rgb_a); end
      end
      if (e_req) exp_q.push_back(pat(e_x, e_y));
      if (req_a && first_req < 0) first_req = cyc_a;
      if (ven_a && v == 35) ven_line35++;
      if (cyc_a == 28782) begin
        n_cmp++; if (req_a !== 1'b1 || xpos_a !== 10'd639) begin
          n_err++; $display("FAIL last_req cyc=28782 got=req%b x%0d exp=req1 x639", req_a, xpos_a);
        end
      end
      @(negedge vga_clk); cyc_a++;
    end
    n_cmp++; if (first_req != 28143) begin n_err++; $display("FAIL first_req got=%0d exp=28143", first_req); end
    n_cmp++; if (ven_line35 != 640) begin n_err++; $display("FAIL ven_count got=%0d exp=640", ven_line35); end
    $display("test_active_window: checked through cycle %0d, first request at %0d", last, first_req);
  endtask

  // One-cycle reset at h=400, v=36, then the sync sequence must restart.
  task automatic test_midline_reset();
    while (cyc_a < 36 * 800 + 400) begin
      @(negedge vga_clk); cyc_a++;
    end
    rst_a = 1'b1;
    @(negedge vga_clk);
    exp_q.delete();
    n_cmp++; if (hs_a !== 1'b0 || vs_a !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_sync got=hs%b vs%b exp=hs0 vs0", hs_a, vs_a);
    end
    n_cmp++; if (req_a !== 1'b0 || ven_a !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_req got=req%b ven%b exp=0/0", req_a, ven_a);
    end
    n_cmp++; if (rgb_a !== 16'h0) begin n_err++; $display("FAIL rst_mid_rgb got=%h exp=0000", rgb_a); end
    n_cmp++; if (xpos_a !== 10'd0 || ypos_a !== 10'd0) begin
      n_err++; $display("FAIL rst_mid_pos got=%0d,%0d exp=0,0", xpos_a, ypos_a);
    end
    rst_a = 1'b0;
    cyc_a = 0;
    $display("test_midline_reset: reset applied at h=400 v=36");
    test_sync_timing(1700, "after_reset");
  endtask

  // Small raster: frame_tick over three frames.
  task automatic test_frame_tick();
    int ticks[$];
    logic e_tick;
    repeat (2) @(negedge vga_clk);
    n_cmp++; if (tick_b !== 1'b0) begin n_err++; $display("FAIL tick_in_reset got=%b exp=0", tick_b); end
    rst_b = 1'b0;
    cyc_b = 0;
    while (cyc_b <= 3 * B_FRAME + 20) begin
      e_tick = ((cyc_b % B_FRAME) == B_TICK);
      n_cmp++; if (tick_b !== e_tick) begin n_err++; $display("FAIL tick cyc=%0d got=%b exp=%b", cyc_b, tick_b, e_tick); end
      if (tick_b) ticks.push_back(cyc_b);
      @(negedge vga_clk); cyc_b++;
    end
    n_cmp++; if (ticks.size() != 3) begin n_err++; $display("FAIL tick_count got=%0d exp=3", ticks.size()); end
    if (ticks.size() == 3) begin
      n_cmp++; if (ticks[0] != B_TICK) begin n_err++; $display("FAIL tick_first got=%0d exp=%0d", ticks[0], B_TICK); end
      n_cmp++; if (ticks[1] - ticks[0] != B_FRAME || ticks[2] - ticks[1] != B_FRAME) begin
        n_err++; $display("FAIL tick_spacing got=%0d,%0d exp=%0d", ticks[1] - ticks[0], ticks[2] - ticks[1], B_FRAME);
      end
    end
    $display("test_frame_tick: %0d ticks seen", ticks.size());
  endtask

  // Small raster: frame wrap at the last pixel and row sequence of requests.
  task automatic test_frame_wrap();
    int h, v, next_row, rows_seen;
    logic e_hs, e_vs, e_req, e_ven;
    logic [9:0] e_x, e_y;
    next_row = 0;
    rows_seen = 0;
    while (cyc_b <= 5 * B_FRAME + 2) begin
      h = cyc_b % B_HT;
      v = (cyc_b / B_HT) % B_VT;
      e_hs = (h < B_HS);
      e_vs = (v < B_VS);
      e_req = (h >= 6 && h <= 13 && v >= 5 && v <= 10);
      e_ven = (h >= 7 && h <= 14 && v >= 5 && v <= 10);
      e_x = e_req ? 10'(h - 6) : 10'd0;
      e_y = e_req ? 10'(v - 5) : 10'd0;
      n_cmp++; if (hs_b !== e_hs || vs_b !== e_vs) begin
        n_err++; $display("FAIL wrap_sync cyc=%0d got=hs%b vs%b exp=hs%b vs%b", cyc_b, hs_b, vs_b, e_hs, e_vs);
      end
      n_cmp++; if (req_b !== e_req || xpos_b !== e_x || ypos_b !== e_y) begin
        n_err++; $display("FAIL wrap_req cyc=%0d got=%b %0d,%0d exp=%b %0d,%0d", cyc_b, req_b, xpos_b, ypos_b, e_req, e_x, e_y);
      end
      n_cmp++; if (ven_b !== e_ven || rgb_b !== (e_ven ? 16'hF800 : 16'h0000)) begin
        n_err++; $display("FAIL wrap_rgb cyc=%0d got=ven%b %h exp=ven%b", cyc_b, ven_b, rgb_b, e_ven);
      end
      if (req_b && xpos_b == 10'd0) begin
        n_cmp++; if (ypos_b !== 10'(next_row)) begin
          n_err++; $display("FAIL row_seq cyc=%0d got=%0d exp=%0d", cyc_b, ypos_b, next_row);
        end
        next_row = (next_row + 1) % B_VD;
        rows_seen++;
      end
      @(negedge vga_clk); cyc_b++;
    end
    n_cmp++; if (rows_seen != 2 * B_VD) begin n_err++; $display("FAIL rows_seen got=%0d exp=%0d", rows_seen, 2 * B_VD); end
    $display("test_frame_wrap: %0d request rows seen", rows_seen);
  endtask

  initial begin
    test_reset();
    test_sync_timing(1700, "sync_timing");
    test_active_window(36 * 800 + 399);
    test_midline_reset();
    test_frame_tick();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(40 * 100000);
    $display("FAIL timeout cyc_a=%0d cyc_b=%0d", cyc_a, cyc_b);
    $fatal(1, "timeout");
  end

endmodule
